// File: rtl/vga_timing_gen.sv
// VGA raster timing generator.
// A clock-enable divider produces one pixel tick every CLK_DIV system clocks.
// On each tick the horizontal/vertical counters advance, and sync, visible-area
// and start-of-line/frame flags are re-derived from the new counter values.
// Every output is a register, so all outputs change on the same clock edge.
module vga_timing_gen #(
    parameter int CLK_DIV   = 4,
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter int SYNC_POL  = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    output logic       pixel_tick,
    output logic [9:0] h_cnt,
    output logic [9:0] v_cnt,
    output logic       hsync,
    output logic       vsync,
    output logic       valid,
    output logic       line_start,
    output logic       frame_start
);

    // Raster geometry, expressed at counter width. Totals must fit 10 bits.
    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS_END  = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS_END  = 10'(V_VISIBLE);
    localparam logic [9:0] HS_START   = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HS_END     = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0] VS_START   = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VS_END     = 10'(V_VISIBLE + V_FRONT + V_SYNC);

    // Active and idle levels of the sync outputs.
    localparam logic SYNC_ACT  = (SYNC_POL != 0) ? 1'b1 : 1'b0;
    localparam logic SYNC_IDLE = ~SYNC_ACT;

    // Tick strobe: high on the edge that registers pixel_tick=1.
    logic w_tick;

    // Divider. With CLK_DIV=1 every enabled clock is a pixel, so no counter
    // is built at all; otherwise a small wrap counter gates the tick.
    generate
        if (CLK_DIV <= 1) begin : g_no_div
            assign w_tick = en;
        end else begin : g_div
            localparam int DW = $clog2(CLK_DIV);
            localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

            logic [DW-1:0] r_div;
            logic          w_div_wrap;

            assign w_div_wrap = (r_div == DIV_LAST);
            assign w_tick     = en && w_div_wrap;

            // Divider counts only while enabled so a pause resumes mid-period.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_div <= '0;
                end else if (en) begin
                    r_div <= w_div_wrap ? '0 : r_div + DW'(1);
                end
            end
        end
    endgenerate

    // Registered outputs.
    logic [9:0] r_h_cnt;
    logic [9:0] r_v_cnt;
    logic       r_hsync;
    logic       r_vsync;
    logic       r_valid;
    logic       r_pixel_tick;
    logic       r_line_start;
    logic       r_frame_start;

    // Next-pixel values; all flags are derived from these so they line up
    // with the counters they describe.
    logic [9:0] w_h_next;
    logic [9:0] w_v_next;
    logic       w_h_wrap;
    logic       w_hsync_next;
    logic       w_vsync_next;
    logic       w_valid_next;
    logic       w_line_start_next;
    logic       w_frame_start_next;

    // Counter advance and per-pixel flag decode for the upcoming pixel.
    always_comb begin
        w_h_wrap = (r_h_cnt == H_LAST);
        w_h_next = r_h_cnt + 10'd1;
        w_v_next = r_v_cnt;
        if (w_h_wrap) begin
            w_h_next = '0;
            w_v_next = (r_v_cnt == V_LAST) ? 10'd0 : r_v_cnt + 10'd1;
        end

        w_hsync_next = SYNC_IDLE;
        if ((w_h_next >= HS_START) && (w_h_next < HS_END)) begin
            w_hsync_next = SYNC_ACT;
        end

        w_vsync_next = SYNC_IDLE;
        if ((w_v_next >= VS_START) && (w_v_next < VS_END)) begin
            w_vsync_next = SYNC_ACT;
        end

        w_valid_next       = (w_h_next < H_VIS_END) && (w_v_next < V_VIS_END);
        w_line_start_next  = (w_h_next == 10'd0);
        w_frame_start_next = (w_h_next == 10'd0) && (w_v_next == 10'd0);
    end

    // Output register: reset parks the raster on its last pixel so the very
    // first tick wraps to (0,0); pulses are zero except on a tick edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_h_cnt       <= H_LAST;
            r_v_cnt       <= V_LAST;
            r_hsync       <= SYNC_IDLE;
            r_vsync       <= SYNC_IDLE;
            r_valid       <= 1'b0;
            r_pixel_tick  <= 1'b0;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_pixel_tick  <= w_tick;
            r_line_start  <= w_tick && w_line_start_next;
            r_frame_start <= w_tick && w_frame_start_next;
            if (w_tick) begin
                r_h_cnt <= w_h_next;
                r_v_cnt <= w_v_next;
                r_hsync <= w_hsync_next;
                r_vsync <= w_vsync_next;
                r_valid <= w_valid_next;
            end
        end
    end

    assign pixel_tick  = r_pixel_tick;
    assign h_cnt       = r_h_cnt;
    assign v_cnt       = r_v_cnt;
    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign valid       = r_valid;
    assign line_start  = r_line_start;
    assign frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Testbench for vga_timing_gen: two instances on a shrunken raster (one with
// a divider of 4 and active-low sync, one undivided with active-high sync)
// driven by randomized enable/reset, compared every clock against a model
// that derives the raster position from the number of enabled clocks.
module tb_vga_timing_gen;

    localparam int HV = 20, HF = 3, HS = 4, HB = 5;
    localparam int VV = 10, VF = 2, VS = 2, VB = 3;
    localparam int HT = HV + HF + HS + HB;   // 32
    localparam int VT = VV + VF + VS + VB;   // 17

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en  = 1'b0;

    logic       pt0, hs0, vs0, vl0, ls0, fs0;
    logic [9:0] h0, v0;
    logic       pt1, hs1, vs1, vl1, ls1, fs1;
    logic [9:0] h1, v1;

    int n_checks = 0;
    int n_pass   = 0;

    // Model state: enabled, non-reset edges since the last reset.
    int n_en      = 0;
    bit edge_en   = 1'b0;

    always #5 clk = ~clk;

    vga_timing_gen #(
        .CLK_DIV(4), .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB), .SYNC_POL(0)
    ) dut0 (
        .clk(clk), .rst(rst), .en(en), .pixel_tick(pt0), .h_cnt(h0), .v_cnt(v0),
        .hsync(hs0), .vsync(vs0), .valid(vl0), .line_start(ls0), .frame_start(fs0)
    );

    vga_timing_gen #(
        .CLK_DIV(1), .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB), .SYNC_POL(1)
    ) dut1 (
        .clk(clk), .rst(rst), .en(en), .pixel_tick(pt1), .h_cnt(h1), .v_cnt(v1),
        .hsync(hs1), .vsync(vs1), .valid(vl1), .line_start(ls1), .frame_start(fs1)
    );

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t n_en=%0d)", tag, obs, exp, $time, n_en);
    endtask

    // Expected outputs: pixel k (1-based) since reset sits at raster index k-1.
    task automatic check_dut(input string nm, input int d, input int pol,
                             input int h, input int v, input int hs, input int vs,
                             input int vl, input int pt, input int ls, input int fs);
        int k, q, eh, ev, ehs, evs, evl, ept, els, efs;
        k   = n_en / d;
        ept = (edge_en && (n_en % d == 0)) ? 1 : 0;
        if (k == 0) begin
            eh = HT - 1; ev = VT - 1; ehs = 1 - pol; evs = 1 - pol; evl = 0;
        end else begin
            q   = k - 1;
            eh  = q % HT;
            ev  = (q / HT) % VT;
            ehs = (eh >= HV + HF && eh < HV + HF + HS) ? pol : 1 - pol;
            evs = (ev >= VV + VF && ev < VV + VF + VS) ? pol : 1 - pol;
            evl = (eh < HV && ev < VV) ? 1 : 0;
        end
        els = (ept == 1 && eh == 0) ? 1 : 0;
        efs = (els == 1 && ev == 0) ? 1 : 0;
        check({nm, ".h_cnt"},       h,  eh);
        check({nm, ".v_cnt"},       v,  ev);
        check({nm, ".hsync"},       hs, ehs);
        check({nm, ".vsync"},       vs, evs);
        check({nm, ".valid"},       vl, evl);
        check({nm, ".pixel_tick"},  pt, ept);
        check({nm, ".line_start"},  ls, els);
        check({nm, ".frame_start"}, fs, efs);
    endtask

    // One clock: apply inputs, advance the model on the edge, sample 1 ns later.
    task automatic cycle(input bit r, input bit e);
        rst = r;
        en  = e;
        @(posedge clk);
        if (r) begin
            n_en = 0; edge_en = 1'b0;
        end else if (e) begin
            n_en++; edge_en = 1'b1;
        end else begin
            edge_en = 1'b0;
        end
        #1;
        check_dut("d4", 4, 0, int'(h0), int'(v0), int'(hs0), int'(vs0),
                  int'(vl0), int'(pt0), int'(ls0), int'(fs0));
        check_dut("d1", 1, 1, int'(h1), int'(v1), int'(hs1), int'(vs1),
                  int'(vl1), int'(pt1), int'(ls1), int'(fs1));
    endtask

    initial begin
        // Reset with enable high, then a clean run past a full d4 frame.
        cycle(1'b1, 1'b1);
        cycle(1'b1, 1'b1);
        for (int i = 0; i < 2400; i++) cycle(1'b0, 1'b1);

        // Pause mid pixel period, then resume.
        for (int i = 0; i < 2; i++)  cycle(1'b0, 1'b1);
        for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0);
        for (int i = 0; i < 20; i++) cycle(1'b0, 1'b1);

        // Reset mid-frame, once enabled and once while paused.
        cycle(1'b1, 1'b1);
        for (int i = 0; i < 700; i++) cycle(1'b0, 1'b1);
        cycle(1'b1, 1'b0);
        cycle(1'b0, 1'b0);

        // Randomized enable bursts with occasional resets.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 1499) == 0) begin
                cycle(1'b1, 1'($urandom_range(0, 1)));
            end else if ($urandom_range(0, 40) == 0) begin
                int len;
                len = $urandom_range(1, 12);
                for (int j = 0; j < len; j++) cycle(1'b0, 1'b0);
            end else begin
                cycle(1'b0, 1'($urandom_range(0, 15) != 0));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
